// File: rtl/riot_pkg.sv
// rtl/riot_pkg.sv - register map, bit positions, prescale table and channel state type
package riot_pkg;

    localparam logic [2:0] REG_CNT_LO    = 3'd0;
    localparam logic [2:0] REG_CNT_HI    = 3'd1;
    localparam logic [2:0] REG_CTRL      = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_EDGE_CTRL = 3'd4;
    localparam logic [2:0] REG_EDGE_STAT = 3'd5;

    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_RELOAD  = 3;
    localparam int CTRL_START   = 4;
    localparam int STAT_EXPIRED = 0;
    localparam int EDGE_POL     = 0;
    localparam int EDGE_IRQ_EN  = 1;
    localparam int EDGE_FLAG    = 0;

    localparam logic [1:0] PS_1    = 2'd0;
    localparam logic [1:0] PS_8    = 2'd1;
    localparam logic [1:0] PS_64   = 2'd2;
    localparam logic [1:0] PS_1024 = 2'd3;

    localparam int unsigned PS_DIV [4] = '{1, 8, 64, 1024};

    typedef enum logic [1:0] {IDLE, RUN, FAST} tmr_state_t;

    // Terminal prescaler value (div-1) for a prescale encoding.
    function automatic logic [9:0] ps_last(input logic [1:0] ps);
        logic [9:0] r;
        case (ps)
            PS_1:    r = 10'(PS_DIV[0] - 1);
            PS_8:    r = 10'(PS_DIV[1] - 1);
            PS_64:   r = 10'(PS_DIV[2] - 1);
            PS_1024: r = 10'(PS_DIV[3] - 1);
            default: r = 10'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riot_timer_bank_if.sv
// rtl/riot_timer_bank_if.sv - chip bus for the timer bank
// Signals: enable (block select), we_n (1=read 0=write), A {channel, reg}, DI write data,
// DO registered read data, OE read-data valid.
interface riot_timer_bank_if #(parameter int AW = 4) ();
    logic          enable;
    logic          we_n;
    logic [AW-1:0] A;
    logic [7:0]    DI;
    logic [7:0]    DO;
    logic          OE;

    modport master (output enable, we_n, A, DI, input DO, OE);
    modport slave  (input enable, we_n, A, DI, output DO, OE);
endinterface

// File: rtl/riot_timer_ch.sv
// rtl/riot_timer_ch.sv - one interval timer channel: stage, count, ctrl, prescaler, FSM
// Ports: clk/rst; sel (this channel, regs 0..3, bus enabled), we_n, reg_idx, di from the bus;
// rd_data is the combinational register read value; expired and irq_en feed the irq OR.
module riot_timer_ch
    import riot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       we_n,
    input  logic [1:0] reg_idx,
    input  logic [7:0] di,
    output logic [7:0] rd_data,
    output logic       expired,
    output logic       irq_en
);

    tmr_state_t       state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] stage, stage_n;
    logic [9:0]       psc, psc_n;
    logic [1:0]       ps;
    logic             reload;
    logic             running;
    logic             tick;
    logic             exp_set;
    logic [7:0]       cnt_hi;

    logic wr, wr_lo, ctrl_wr, start_wr, stat_w1c;
    assign wr       = sel & ~we_n;
    assign wr_lo    = wr & ({1'b0, reg_idx} == REG_CNT_LO);
    assign ctrl_wr  = wr & ({1'b0, reg_idx} == REG_CTRL);
    assign start_wr = ctrl_wr & di[CTRL_START];
    assign stat_w1c = wr & ({1'b0, reg_idx} == REG_STATUS) & di[STAT_EXPIRED];
    assign running  = (state != IDLE);

    generate
        if (WIDTH == 16) begin : g_w16
            logic       wr_hi;
            logic       rd_lo;
            logic [7:0] hi_latch;
            assign wr_hi = wr & ({1'b0, reg_idx} == REG_CNT_HI);
            assign rd_lo = sel & we_n & ({1'b0, reg_idx} == REG_CNT_LO);
            always_comb begin
                stage_n = stage;
                if (wr_lo) stage_n[7:0]  = di;
                if (wr_hi) stage_n[15:8] = di;
            end
            // A low-byte read freezes the high byte so LO/HI form a coherent pair.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        hi_latch <= 8'h00;
                else if (rd_lo) hi_latch <= count[15:8];
            end
            assign cnt_hi = hi_latch;
        end else begin : g_w8
            always_comb begin
                stage_n = stage;
                if (wr_lo) stage_n = di;
            end
            assign cnt_hi = 8'h00;
        end
    endgenerate

    always_comb begin
        state_n = state;
        count_n = count;
        psc_n   = psc;
        exp_set = 1'b0;
        tick    = (psc >= ps_last(ps));
        case (state)
            IDLE: ;
            RUN: begin
                psc_n = tick ? 10'd0 : psc + 10'd1;
                if (tick) begin
                    if (count != '0) begin
                        count_n = count - 1'b1;
                    end else begin
                        exp_set = 1'b1;
                        if (reload) begin
                            count_n = stage;
                        end else begin
                            count_n = '1;
                            state_n = FAST;
                        end
                    end
                end
            end
            FAST: count_n = count - 1'b1;
            default: state_n = IDLE;
        endcase
        // A start overrides whatever the running channel would have done this edge.
        if (start_wr) begin
            count_n = stage;
            psc_n   = 10'd0;
            state_n = RUN;
            exp_set = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            stage   <= '0;
            psc     <= 10'd0;
            ps      <= 2'd0;
            irq_en  <= 1'b0;
            reload  <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            stage   <= stage_n;
            psc     <= psc_n;
            expired <= exp_set | (expired & ~stat_w1c);
            if (ctrl_wr) begin
                ps     <= di[1:0];
                irq_en <= di[CTRL_IRQ_EN];
                reload <= di[CTRL_RELOAD];
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (reg_idx)
            2'd0:    rd_data = count[7:0];
            2'd1:    rd_data = cnt_hi;
            2'd2:    rd_data = {4'b0000, reload, irq_en, ps};
            default: rd_data = {6'b000000, running, expired};
        endcase
    end

endmodule

// File: rtl/riot_timer_bank.sv
// rtl/riot_timer_bank.sv - NUM_CH interval timers plus edge detector on the chip bus
// Ports: phi2 clock, rst async active-high, bus (slave: enable/we_n/A/DI in, DO/OE out),
// edge_in synchronised pin, irq combined request, irq_en {edge irq_en, channel irq_en}.
module riot_timer_bank
    import riot_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8
) (
    input  logic                 phi2,
    input  logic                 rst,
    riot_timer_bank_if.slave     bus,
    input  logic                 edge_in,
    output logic                 irq,
    output logic [NUM_CH:0]      irq_en
);

    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NSLOT = 1 << CHW;

    logic [CHW-1:0] chan;
    logic [2:0]     reg_idx;
    logic           rd, wr, glob;

    assign chan    = bus.A[CHW+2:3];
    assign reg_idx = bus.A[2:0];
    assign rd      = bus.enable & bus.we_n;
    assign wr      = bus.enable & ~bus.we_n;
    assign glob    = (chan == '0);

    // Unpopulated channel slots read as zero, so the read mux can index by chan directly.
    logic [7:0]        slot_rd [NSLOT];
    logic [NUM_CH-1:0] ch_exp, ch_ie;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < NUM_CH) begin : g_ch
            riot_timer_ch #(.WIDTH(WIDTH)) u_ch (
                .clk     (phi2),
                .rst     (rst),
                .sel     (bus.enable & ~reg_idx[2] & (chan == CHW'(i))),
                .we_n    (bus.we_n),
                .reg_idx (reg_idx[1:0]),
                .di      (bus.DI),
                .rd_data (slot_rd[i]),
                .expired (ch_exp[i]),
                .irq_en  (ch_ie[i])
            );
        end else begin : g_empty
            assign slot_rd[i] = 8'h00;
        end
    end

    logic edge_pol, edge_ie, edge_flag, edge_prev;
    logic edge_evt, edge_ctrl_wr, edge_w1c;

    assign edge_ctrl_wr = wr & glob & (reg_idx == REG_EDGE_CTRL);
    assign edge_w1c     = wr & glob & (reg_idx == REG_EDGE_STAT) & bus.DI[EDGE_FLAG];
    assign edge_evt     = edge_pol ? (~edge_prev & edge_in) : (edge_prev & ~edge_in);

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            edge_prev <= 1'b0;
            edge_flag <= 1'b0;
            edge_pol  <= 1'b0;
            edge_ie   <= 1'b0;
        end else begin
            edge_prev <= edge_in;
            edge_flag <= edge_evt | (edge_flag & ~edge_w1c);
            if (edge_ctrl_wr) begin
                edge_pol <= bus.DI[EDGE_POL];
                edge_ie  <= bus.DI[EDGE_IRQ_EN];
            end
        end
    end

    logic [7:0] rd_mux;
    always_comb begin
        rd_mux = 8'h00;
        if (!reg_idx[2])
            rd_mux = slot_rd[chan];
        else if (glob && reg_idx == REG_EDGE_CTRL)
            rd_mux = {6'b000000, edge_ie, edge_pol};
        else if (glob && reg_idx == REG_EDGE_STAT)
            rd_mux = {7'b0000000, edge_flag};
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            bus.DO <= 8'h00;
            bus.OE <= 1'b0;
        end else begin
            bus.DO <= rd ? rd_mux : 8'h00;
            bus.OE <= rd;
        end
    end

    assign irq_en = {edge_ie, ch_ie};
    assign irq    = (|(ch_exp & ch_ie)) | (edge_flag & edge_ie);

endmodule

// File: tb/tb_riot_timer_bank.sv
// tb/tb_riot_timer_bank.sv - self-checking bench for riot_timer_bank
module tb_riot_timer_bank;

    logic       phi2 = 1'b0;
    logic       rst  = 1'b1;
    logic       edge8 = 1'b0;
    logic       edge16 = 1'b0;
    logic       irq8, irq16;
    logic [2:0] ie8;
    logic [3:0] ie16;

    riot_timer_bank_if #(.AW(4)) b8 ();
    riot_timer_bank_if #(.AW(5)) b16 ();

    riot_timer_bank #(.NUM_CH(2), .WIDTH(8)) dut8 (
        .phi2(phi2), .rst(rst), .bus(b8), .edge_in(edge8), .irq(irq8), .irq_en(ie8)
    );
    riot_timer_bank #(.NUM_CH(3), .WIDTH(16)) dut16 (
        .phi2(phi2), .rst(rst), .bus(b16), .edge_in(edge16), .irq(irq16), .irq_en(ie16)
    );

    always #5 phi2 = ~phi2;

    int vecs = 0;
    int errs = 0;
    int edge_no = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, access at the next rising edge, return 1 unit later.
    task automatic cyc(input bit d16, input bit en, input bit wn, input logic [4:0] a, input logic [7:0] di);
        @(negedge phi2);
        b8.enable  = 1'b0;
        b16.enable = 1'b0;
        if (d16) begin
            b16.enable = en; b16.we_n = wn; b16.A = a; b16.DI = di;
        end else begin
            b8.enable = en; b8.we_n = wn; b8.A = a[3:0]; b8.DI = di;
        end
        @(posedge phi2);
        edge_no++;
        #1;
    endtask

    task automatic wr(input bit d16, input logic [4:0] a, input logic [7:0] di);
        cyc(d16, 1'b1, 1'b0, a, di);
    endtask

    task automatic rd(input bit d16, input logic [4:0] a, output logic [7:0] dv, output logic ov);
        cyc(d16, 1'b1, 1'b1, a, 8'h00);
        dv = d16 ? b16.DO : b8.DO;
        ov = d16 ? b16.OE : b8.OE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    endtask

    task automatic idle_until(input int m);
        while (edge_no < m) cyc(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Channel state j edges after the start edge, from the timer rules:
    // ticks every D edges; S+1 ticks reach expiry; then reload or free-run down from all-ones.
    task automatic model(input int S, input int D, input bit R, input int j, output int cnt, output bit ex);
        int k;
        k = j / D;
        if (R) begin
            cnt = S - (k % (S + 1));
            ex  = (k >= S + 1);
        end else if (k <= S) begin
            cnt = S - k;
            ex  = 1'b0;
        end else begin
            cnt = (255 - (j - (S + 1) * D)) & 255;
            ex  = 1'b1;
        end
    endtask

    logic [7:0]  dv;
    logic        ov;
    int          s, s3, s4, m;
    logic [15:0] v16;

    initial begin
        b8.enable = 0;  b8.we_n = 1;  b8.A = '0;  b8.DI = '0;
        b16.enable = 0; b16.we_n = 1; b16.A = '0; b16.DI = '0;
        do_reset();

        check("rst_do8", {8'h00, b8.DO}, 16'h0000);
        check("rst_oe8", {15'h0, b8.OE}, 16'h0000);
        check("rst_irq8", {15'h0, irq8}, 16'h0000);
        check("rst_ie16", {12'h0, ie16}, 16'h0000);

        // 1: one-shot, stage 5, /1, irq_en
        wr(0, 5'h00, 8'd5);
        wr(0, 5'h02, 8'h14);
        s = edge_no;
        idle_until(s + 5);
        check("t1_irq_before", {15'h0, irq8}, 16'h0000);
        idle(1);
        check("t1_irq_at6", {15'h0, irq8}, 16'h0001);
        rd(0, 5'h00, dv, ov);
        check("t1_cnt_ff", {8'h00, dv}, 16'h00FF);
        check("t1_oe", {15'h0, ov}, 16'h0001);
        wr(0, 5'h03, 8'h01);
        check("t1_w1c", {15'h0, irq8}, 16'h0000);

        // 2: ch1 reload, stage 2, /8
        wr(0, 5'h08, 8'd2);
        wr(0, 5'h0A, 8'h19);
        s = edge_no;
        rd(0, 5'h08, dv, ov);
        check("t2_cnt2", {8'h00, dv}, 16'd2);
        idle_until(s + 8);  rd(0, 5'h08, dv, ov);
        check("t2_cnt1", {8'h00, dv}, 16'd1);
        idle_until(s + 16); rd(0, 5'h08, dv, ov);
        check("t2_cnt0", {8'h00, dv}, 16'd0);
        idle_until(s + 24); rd(0, 5'h08, dv, ov);
        check("t2_cnt_reload", {8'h00, dv}, 16'd2);
        rd(0, 5'h0B, dv, ov);
        check("t2_stat24", {8'h00, dv}, 16'h0003);
        check("t2_irq0", {15'h0, irq8}, 16'h0000);
        wr(0, 5'h0B, 8'h01);
        idle_until(s + 47); rd(0, 5'h0B, dv, ov);
        check("t2_stat47", {8'h00, dv}, 16'h0002);
        rd(0, 5'h0B, dv, ov);
        check("t2_stat48", {8'h00, dv}, 16'h0003);

        // 3: 16-bit coherent LO/HI
        wr(1, 5'h00, 8'h34);
        wr(1, 5'h01, 8'h12);
        wr(1, 5'h02, 8'h10);
        s = edge_no;
        for (int t = 0; t < 2; t++) begin
            idle_until(s + 52 + t * 7);
            rd(1, 5'h00, dv, ov);
            v16 = 16'h1234 - 16'(edge_no - 1 - s);
            check("t3_lo", {8'h00, dv}, {8'h00, v16[7:0]});
            idle(3);
            rd(1, 5'h01, dv, ov);
            check("t3_hi", {8'h00, dv}, {8'h00, v16[15:8]});
        end

        // 4: W1C vs expiry, start vs expiry
        wr(0, 5'h00, 8'd1);
        wr(0, 5'h02, 8'h14);
        s = edge_no;
        idle_until(s + 1);
        wr(0, 5'h03, 8'h01);
        check("t4_set_wins", {15'h0, irq8}, 16'h0001);
        wr(0, 5'h03, 8'h01);
        check("t4_cleared", {15'h0, irq8}, 16'h0000);
        wr(0, 5'h02, 8'h1C);
        s3 = edge_no;
        idle_until(s3 + 1);
        wr(0, 5'h02, 8'h1C);
        s4 = edge_no;
        check("t4_load_wins", {15'h0, irq8}, 16'h0000);
        rd(0, 5'h00, dv, ov);
        check("t4_cnt_stage", {8'h00, dv}, 16'd1);
        rd(0, 5'h03, dv, ov);
        check("t4_stat", {8'h00, dv}, 16'h0002);
        check("t4_next_expiry", {15'h0, irq8}, 16'h0001);
        wr(0, 5'h01, 8'hAA);
        rd(0, 5'h01, dv, ov);
        check("w8_hi_zero", {8'h00, dv}, 16'h0000);

        // 5: falling-edge detect
        do_reset();
        wr(0, 5'h04, 8'h02);
        check("t5_ie", {13'h0, ie8}, 16'h0004);
        edge8 = 1'b1;
        idle(2);
        check("t5_rise_irq", {15'h0, irq8}, 16'h0000);
        rd(0, 5'h05, dv, ov);
        check("t5_rise_flag", {8'h00, dv}, 16'h0000);
        edge8 = 1'b0;
        idle(1);
        check("t5_fall_irq", {15'h0, irq8}, 16'h0001);
        rd(0, 5'h05, dv, ov);
        check("t5_fall_flag", {8'h00, dv}, 16'h0001);

        // 6: async reset mid-run, unmapped reads
        wr(0, 5'h00, 8'd9);
        wr(0, 5'h02, 8'h1C);
        idle(3);
        rd(0, 5'h00, dv, ov);
        check("t6_cnt", {8'h00, dv}, 16'd6);
        #2 rst = 1'b1;
        #1;
        check("t6_do", {8'h00, b8.DO}, 16'h0000);
        check("t6_oe", {15'h0, b8.OE}, 16'h0000);
        check("t6_irq", {15'h0, irq8}, 16'h0000);
        check("t6_ie", {13'h0, ie8}, 16'h0000);
        idle(1);
        rst = 1'b0;
        rd(0, 5'h03, dv, ov); check("t6_stat", {8'h00, dv}, 16'h0000);
        rd(0, 5'h02, dv, ov); check("t6_ctrl", {8'h00, dv}, 16'h0000);
        rd(0, 5'h00, dv, ov); check("t6_cnt0", {8'h00, dv}, 16'h0000);
        rd(0, 5'h05, dv, ov); check("t6_eflag", {8'h00, dv}, 16'h0000);
        wr(0, 5'h04, 8'h03);
        rd(0, 5'h0C, dv, ov); check("alias_ch1_r4", {7'h0, ov, dv}, 16'h0100);
        rd(0, 5'h04, dv, ov); check("edge_ctrl_rd", {7'h0, ov, dv}, 16'h0103);
        rd(0, 5'h06, dv, ov); check("reg6_zero", {7'h0, ov, dv}, 16'h0100);
        rd(1, 5'h18, dv, ov); check("ch3_absent", {7'h0, ov, dv}, 16'h0100);
        idle(1);
        check("oe_idle", {15'h0, b8.OE}, 16'h0000);

        // Randomised single-channel runs against the model
        for (int it = 0; it < 12; it++) begin
            bit        ch, rl, ie, ex;
            logic [1:0] ps;
            int        S, D, w, cnt;
            do_reset();
            ch = 1'($urandom_range(0, 1));
            ps = 2'($urandom_range(0, 3));
            rl = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            D  = (ps == 2'd0) ? 1 : (ps == 2'd1) ? 8 : (ps == 2'd2) ? 64 : 1024;
            S  = (ps == 2'd3) ? 0 : (ps == 2'd2) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            wr(0, {1'b0, ch, 3'd0}, 8'(S));
            wr(0, {1'b0, ch, 3'd2}, {3'b000, 1'b1, rl, ie, ps});
            s = edge_no;
            w = $urandom_range(0, (S + 2) * D + 10);
            idle(w);
            rd(0, {1'b0, ch, 3'd0}, dv, ov);
            model(S, D, rl, edge_no - 1 - s, cnt, ex);
            check("rnd_cnt", {8'h00, dv}, 16'(cnt));
            rd(0, {1'b0, ch, 3'd3}, dv, ov);
            model(S, D, rl, edge_no - 1 - s, cnt, ex);
            check("rnd_stat", {8'h00, dv}, {14'h0, 1'b1, ex});
            model(S, D, rl, edge_no - s, cnt, ex);
            check("rnd_irq", {15'h0, irq8}, {15'h0, ie & ex});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
